// File: rtl/semnale_peclock.sv
// Three-channel push-button front end: synchronise, debounce and classify each
// press, emitting a one-cycle short/long pulse when the button is released.

module PeclockChannel #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int LONG_CYCLES     = 16,
    parameter int CNT_W           = 8
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_b,
    output logic o_lung,
    output logic o_scurt
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0]    DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DW-1:0]          r_stable;
    logic                   r_deb;
    logic                   r_debPrev;
    logic [CNT_W-1:0]       r_hold;
    logic                   w_s;
    logic                   w_fall;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_fall = !r_deb && r_debPrev;

    // The hold count is still valid on the falling-edge cycle, so the
    // classification reads it while the same edge clears it for the next press.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync    <= '0;
            r_stable  <= '0;
            r_deb     <= 1'b0;
            r_debPrev <= 1'b0;
            r_hold    <= '0;
            o_lung    <= 1'b0;
            o_scurt   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_b};
            r_debPrev <= r_deb;

            if (w_s != r_deb) begin
                if (r_stable == DEB_LAST) begin
                    r_deb    <= w_s;
                    r_stable <= '0;
                end else begin
                    r_stable <= r_stable + 1'b1;
                end
            end else begin
                r_stable <= '0;
            end

            if (r_deb) begin
                if (r_hold < LONG_MAX)
                    r_hold <= r_hold + 1'b1;
            end else begin
                r_hold <= '0;
            end

            o_lung  <= w_fall && (r_hold >= LONG_MAX);
            o_scurt <= w_fall && (r_hold <  LONG_MAX);
        end
    end

endmodule

module semnale_peclock #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int LONG_CYCLES     = 16,
    parameter int CNT_W           = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic b1,
    input  logic b2,
    input  logic b3,
    output logic lung_1,
    output logic lung_2,
    output logic lung_3,
    output logic scurt_1,
    output logic scurt_2,
    output logic scurt_3
);

    PeclockChannel #(
        .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .LONG_CYCLES(LONG_CYCLES), .CNT_W(CNT_W)
    ) u_ch1 (
        .i_clock(clock), .i_reset(reset), .i_b(b1), .o_lung(lung_1), .o_scurt(scurt_1)
    );

    PeclockChannel #(
        .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .LONG_CYCLES(LONG_CYCLES), .CNT_W(CNT_W)
    ) u_ch2 (
        .i_clock(clock), .i_reset(reset), .i_b(b2), .o_lung(lung_2), .o_scurt(scurt_2)
    );

    PeclockChannel #(
        .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .LONG_CYCLES(LONG_CYCLES), .CNT_W(CNT_W)
    ) u_ch3 (
        .i_clock(clock), .i_reset(reset), .i_b(b3), .o_lung(lung_3), .o_scurt(scurt_3)
    );

endmodule

// File: tb/tb_semnale_peclock.sv
// Directed bench for semnale_peclock: glitch rejection, short/long boundary,
// bounce, channel independence and reset behaviour.

module tb_semnale_peclock;

    logic clock = 1'b0;
    logic reset;
    logic [2:0] b;
    logic lung_1, lung_2, lung_3, scurt_1, scurt_2, scurt_3;

    int nVec = 0;
    int nMis = 0;
    int cyc  = 0;

    int lungCnt [3];
    int scurtCnt[3];
    int lungAt  [3];
    int scurtAt [3];
    int wideCnt;
    int bothCnt;
    int deb1Seen;
    logic [2:0] prevL, prevS;

    always #5 clock = ~clock;

    semnale_peclock dut (
        .clock(clock), .reset(reset),
        .b1(b[0]), .b2(b[1]), .b3(b[2]),
        .lung_1(lung_1), .lung_2(lung_2), .lung_3(lung_3),
        .scurt_1(scurt_1), .scurt_2(scurt_2), .scurt_3(scurt_3)
    );

    task automatic clearObs();
        for (int k = 0; k < 3; k++) begin
            lungCnt[k] = 0; scurtCnt[k] = 0; lungAt[k] = -1; scurtAt[k] = -1;
        end
        wideCnt = 0; bothCnt = 0; deb1Seen = 0;
    endtask

    // Advance n cycles, recording pulse starts and widths at each falling edge.
    task automatic tick(input int n);
        logic [2:0] l, s;
        repeat (n) begin
            @(negedge clock);
            cyc++;
            l = {lung_3, lung_2, lung_1};
            s = {scurt_3, scurt_2, scurt_1};
            for (int k = 0; k < 3; k++) begin
                if (l[k]) begin
                    if (prevL[k]) wideCnt++;
                    else begin lungCnt[k]++; lungAt[k] = cyc; end
                end
                if (s[k]) begin
                    if (prevS[k]) wideCnt++;
                    else begin scurtCnt[k]++; scurtAt[k] = cyc; end
                end
            end
            if ((l & s) != 3'b000) bothCnt++;
            if (dut.u_ch1.r_deb) deb1Seen = 1;
            prevL = l;
            prevS = s;
        end
    endtask

    task automatic test_reset();
        int total;
        reset = 1'b1;
        b = 3'b000;
        clearObs();
        for (int i = 0; i < 100; i++) begin
            b = 3'(i / 4);
            tick(1);
        end
        total = lungCnt[0] + lungCnt[1] + lungCnt[2] + scurtCnt[0] + scurtCnt[1] + scurtCnt[2];
        nVec++;
        if (total !== 0) begin
            nMis++; $display("[TB] FAIL reset_hold_pulses: got %0d, expected 0", total);
        end
        nVec++;
        if ({lung_1, lung_2, lung_3, scurt_1, scurt_2, scurt_3} !== 6'b0) begin
            nMis++; $display("[TB] FAIL reset_outputs: got %b, expected 000000",
                             {lung_1, lung_2, lung_3, scurt_1, scurt_2, scurt_3});
        end
        b = 3'b000;
        tick(1);
        reset = 1'b0;
        clearObs();
        tick(30);
        total = lungCnt[0] + lungCnt[1] + lungCnt[2] + scurtCnt[0] + scurtCnt[1] + scurtCnt[2];
        nVec++;
        if (total !== 0) begin
            nMis++; $display("[TB] FAIL reset_release_pulses: got %0d, expected 0", total);
        end
    endtask

    task automatic test_glitch();
        clearObs();
        b[0] = 1'b1; tick(1);
        b[0] = 1'b0; tick(1);
        b[0] = 1'b1; tick(1);
        b[0] = 1'b0; tick(25);
        nVec++;
        if (lungCnt[0] + scurtCnt[0] !== 0) begin
            nMis++; $display("[TB] FAIL glitch_pulse: got %0d, expected 0", lungCnt[0] + scurtCnt[0]);
        end
        nVec++;
        if (deb1Seen !== 0) begin
            nMis++; $display("[TB] FAIL glitch_d1: got %0d, expected 0", deb1Seen);
        end
    endtask

    task automatic test_short();
        int relCyc;
        clearObs();
        b[0] = 1'b1; tick(6);
        b[0] = 1'b0; relCyc = cyc;
        tick(25);
        nVec++;
        if (scurtCnt[0] !== 1) begin
            nMis++; $display("[TB] FAIL short_scurt1_count: got %0d, expected 1", scurtCnt[0]);
        end
        nVec++;
        if (lungCnt[0] !== 0) begin
            nMis++; $display("[TB] FAIL short_lung1_count: got %0d, expected 0", lungCnt[0]);
        end
        nVec++;
        if (scurtAt[0] - relCyc !== 6) begin
            nMis++; $display("[TB] FAIL short_latency: got %0d, expected 6", scurtAt[0] - relCyc);
        end
        nVec++;
        if (wideCnt !== 0) begin
            nMis++; $display("[TB] FAIL short_width: got %0d extra cycles, expected 0", wideCnt);
        end
    endtask

    task automatic test_boundary();
        clearObs();
        b[1] = 1'b1; tick(15);
        b[1] = 1'b0; tick(25);
        nVec++;
        if ({lungCnt[1], scurtCnt[1]} !== {32'd0, 32'd1}) begin
            nMis++; $display("[TB] FAIL boundary15: got lung=%0d scurt=%0d, expected lung=0 scurt=1",
                             lungCnt[1], scurtCnt[1]);
        end
        clearObs();
        b[1] = 1'b1; tick(16);
        b[1] = 1'b0; tick(25);
        nVec++;
        if ({lungCnt[1], scurtCnt[1]} !== {32'd1, 32'd0}) begin
            nMis++; $display("[TB] FAIL boundary16: got lung=%0d scurt=%0d, expected lung=1 scurt=0",
                             lungCnt[1], scurtCnt[1]);
        end
        clearObs();
        b[0] = 1'b1; tick(10);
        b[0] = 1'b0; tick(25);
        nVec++;
        if ({lungCnt[0], scurtCnt[0]} !== {32'd0, 32'd1}) begin
            nMis++; $display("[TB] FAIL boundary10_ch1: got lung=%0d scurt=%0d, expected lung=0 scurt=1",
                             lungCnt[0], scurtCnt[0]);
        end
    endtask

    task automatic test_long_bounce();
        int others;
        clearObs();
        b[2] = 1'b1; tick(1);
        b[2] = 1'b0; tick(1);
        b[2] = 1'b1; tick(25);
        b[2] = 1'b0; tick(1);
        b[2] = 1'b1; tick(1);
        b[2] = 1'b0; tick(25);
        nVec++;
        if ({lungCnt[2], scurtCnt[2]} !== {32'd1, 32'd0}) begin
            nMis++; $display("[TB] FAIL long_bounce_ch3: got lung=%0d scurt=%0d, expected lung=1 scurt=0",
                             lungCnt[2], scurtCnt[2]);
        end
        others = lungCnt[0] + lungCnt[1] + scurtCnt[0] + scurtCnt[1];
        nVec++;
        if (others !== 0) begin
            nMis++; $display("[TB] FAIL long_bounce_others: got %0d, expected 0", others);
        end
    endtask

    task automatic test_back_to_back();
        clearObs();
        b[0] = 1'b1; tick(12);
        b[1] = 1'b1; tick(8);
        b[0] = 1'b0; b[1] = 1'b0;
        tick(25);
        nVec++;
        if ({lungCnt[0], scurtCnt[0]} !== {32'd1, 32'd0}) begin
            nMis++; $display("[TB] FAIL indep_ch1: got lung=%0d scurt=%0d, expected lung=1 scurt=0",
                             lungCnt[0], scurtCnt[0]);
        end
        nVec++;
        if ({lungCnt[1], scurtCnt[1]} !== {32'd0, 32'd1}) begin
            nMis++; $display("[TB] FAIL indep_ch2: got lung=%0d scurt=%0d, expected lung=0 scurt=1",
                             lungCnt[1], scurtCnt[1]);
        end
        nVec++;
        if (lungAt[0] !== scurtAt[1] || lungAt[0] < 0) begin
            nMis++; $display("[TB] FAIL indep_same_cycle: got lung_1 at %0d scurt_2 at %0d, expected equal",
                             lungAt[0], scurtAt[1]);
        end
        nVec++;
        if (bothCnt !== 0) begin
            nMis++; $display("[TB] FAIL indep_exclusive: got %0d, expected 0", bothCnt);
        end
    endtask

    task automatic test_reset_mid_press();
        clearObs();
        b[2] = 1'b1; tick(10);
        reset = 1'b1; tick(10);
        b[2] = 1'b0; tick(10);
        reset = 1'b0; tick(30);
        nVec++;
        if (lungCnt[2] + scurtCnt[2] !== 0) begin
            nMis++; $display("[TB] FAIL reset_mid_press: got %0d pulses, expected 0",
                             lungCnt[2] + scurtCnt[2]);
        end
        // After recovery the channel must still classify a fresh press.
        clearObs();
        b[2] = 1'b1; tick(20);
        b[2] = 1'b0; tick(25);
        nVec++;
        if ({lungCnt[2], scurtCnt[2]} !== {32'd1, 32'd0}) begin
            nMis++; $display("[TB] FAIL reset_recovery: got lung=%0d scurt=%0d, expected lung=1 scurt=0",
                             lungCnt[2], scurtCnt[2]);
        end
    endtask

    initial begin
        prevL = 3'b000;
        prevS = 3'b000;
        reset = 1'b1;
        b = 3'b000;
        test_reset();
        test_glitch();
        test_short();
        test_boundary();
        test_long_bounce();
        test_back_to_back();
        test_reset_mid_press();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
